// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared defaults, types and saturating add for the cmp MAC processing element
package cmp_pkg;

  localparam int DEF_DATA_WID = 16;
  localparam int DEF_ACC_WID  = 40;
  localparam int DEF_MULT_LAT = 2;
  localparam int DEF_K_WID    = 8;

  typedef logic signed [DEF_DATA_WID-1:0] data_t;
  typedef logic signed [DEF_ACC_WID-1:0]  acc_t;
  typedef logic        [DEF_K_WID-1:0]    klen_t;

  // Adds two sign-extended operands and clamps to the signed range of a w-bit accumulator (w <= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int               w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi)      return hi[63:0];
    else if (s < lo) return lo[63:0];
    return s[63:0];
  endfunction

endpackage

// File: rtl/cmp_mult_pipe.sv
// rtl/cmp_mult_pipe.sv - signed multiplier with MULT_LAT enable-gated stages carrying valid/last sideband
module cmp_mult_pipe #(
  parameter int DATA_WID = 16,
  parameter int ACC_WID  = 40,
  parameter int MULT_LAT = 2
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic                       i_valid,
  input  logic                       i_last,
  input  logic signed [DATA_WID-1:0] i_a,
  input  logic signed [DATA_WID-1:0] i_b,
  output logic                       o_valid,
  output logic                       o_last,
  output logic signed [ACC_WID-1:0]  o_prod,
  output logic                       o_busy
);

  logic signed [2*DATA_WID-1:0] w_full;
  logic signed [ACC_WID-1:0]    r_prod [MULT_LAT];
  logic [MULT_LAT-1:0]          r_v;
  logic [MULT_LAT-1:0]          r_l;

  assign w_full = i_a * i_b;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_v <= '0;
      r_l <= '0;
      for (int i = 0; i < MULT_LAT; i++) r_prod[i] <= '0;
    end else if (i_en) begin
      r_v[0]    <= i_valid;
      r_l[0]    <= i_last;
      r_prod[0] <= ACC_WID'(w_full);
      for (int i = 1; i < MULT_LAT; i++) begin
        r_v[i]    <= r_v[i-1];
        r_l[i]    <= r_l[i-1];
        r_prod[i] <= r_prod[i-1];
      end
    end
  end

  assign o_valid = r_v[MULT_LAT-1];
  assign o_last  = r_l[MULT_LAT-1];
  assign o_prod  = r_prod[MULT_LAT-1];
  assign o_busy  = |r_v;

endmodule

// File: rtl/cmp_mac_unit.sv
// rtl/cmp_mac_unit.sv - signed MAC PE: K products per partial sum, valid/ready out; CMP_MAC_SAT_EN selects saturation
module cmp_mac_unit
  import cmp_pkg::*;
#(
  parameter int DATA_WID = DEF_DATA_WID,
  parameter int ACC_WID  = DEF_ACC_WID,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int K_WID    = DEF_K_WID
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_WID-1:0] weight,
  input  logic signed [DATA_WID-1:0] pixel,
  input  logic [K_WID-1:0]           k_len,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_WID-1:0]  psum_out,
  output logic                       busy
);

  logic                       w_en;
  logic                       w_accept;
  logic                       w_last;
  logic [K_WID-1:0]           w_kl;
  logic [K_WID-1:0]           r_cnt;
  logic [K_WID-1:0]           r_kl;
  logic                       r_in_v;
  logic                       r_in_l;
  logic signed [DATA_WID-1:0] r_in_a;
  logic signed [DATA_WID-1:0] r_in_b;
  logic                       w_mv;
  logic                       w_ml;
  logic                       w_pipe_busy;
  logic signed [ACC_WID-1:0]  w_mp;
  logic signed [ACC_WID-1:0]  w_base;
  logic signed [ACC_WID-1:0]  w_sum;
  logic signed [ACC_WID-1:0]  r_acc;
  logic signed [ACC_WID-1:0]  r_psum;
  logic                       r_first;
  logic                       r_out_v;

  assign w_en     = !r_out_v || out_ready;
  assign in_ready = w_en && !rst;
  assign w_accept = in_valid && in_ready;
  // k_len only matters on the first beat; later beats use the latched group length.
  assign w_kl     = (r_cnt != '0) ? r_kl : ((k_len == '0) ? K_WID'(1) : k_len);
  assign w_last   = (r_cnt == w_kl - K_WID'(1));

  always_ff @(posedge clock) begin
    if (rst) begin
      r_cnt  <= '0;
      r_kl   <= '0;
      r_in_v <= 1'b0;
      r_in_l <= 1'b0;
      r_in_a <= '0;
      r_in_b <= '0;
    end else if (w_en) begin
      r_in_v <= w_accept;
      r_in_l <= w_accept && w_last;
      if (w_accept) begin
        r_in_a <= weight;
        r_in_b <= pixel;
        r_kl   <= w_kl;
        r_cnt  <= w_last ? '0 : r_cnt + K_WID'(1);
      end
    end
  end

  cmp_mult_pipe #(
    .DATA_WID (DATA_WID),
    .ACC_WID  (ACC_WID),
    .MULT_LAT (MULT_LAT)
  ) u_mult (
    .clock   (clock),
    .rst     (rst),
    .i_en    (w_en),
    .i_valid (r_in_v),
    .i_last  (r_in_l),
    .i_a     (r_in_a),
    .i_b     (r_in_b),
    .o_valid (w_mv),
    .o_last  (w_ml),
    .o_prod  (w_mp),
    .o_busy  (w_pipe_busy)
  );

  assign w_base = r_first ? '0 : r_acc;

`ifdef CMP_MAC_SAT_EN
  logic                      r_sat;
  logic                      w_sat_hold;
  logic                      w_sat_next;
  logic signed [ACC_WID-1:0] w_clamp;

  // Once a group clamps, the accumulator stays pinned at the rail until the group ends.
  assign w_clamp    = ACC_WID'(sat_add(64'(w_base), 64'(w_mp), ACC_WID));
  assign w_sat_hold = !r_first && r_sat;
  assign w_sum      = w_sat_hold ? r_acc : w_clamp;
  assign w_sat_next = w_sat_hold || (w_clamp != w_base + w_mp);

  always_ff @(posedge clock) begin
    if (rst)                r_sat <= 1'b0;
    else if (w_en && w_mv)  r_sat <= !w_ml && w_sat_next;
  end
`else
  assign w_sum = w_base + w_mp;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      r_acc   <= '0;
      r_psum  <= '0;
      r_first <= 1'b1;
      r_out_v <= 1'b0;
    end else if (w_en) begin
      if (r_out_v) r_out_v <= 1'b0;
      if (w_mv) begin
        r_first <= w_ml;
        if (w_ml) begin
          r_psum  <= w_sum;
          r_out_v <= 1'b1;
          r_acc   <= '0;
        end else begin
          r_acc   <= w_sum;
        end
      end
    end
  end

  assign out_valid = r_out_v;
  assign psum_out  = r_psum;
  assign busy      = (r_cnt != '0) || r_in_v || w_pipe_busy;

endmodule

// File: doc/cmp_mac_unit.md
Name: cmp_mac_unit

Overview:
- Parametrised signed multiply-accumulate processing element for the sDavinci cube array. It is the successor to the single-cycle multiplier PE.
- Accepts a stream of weight/pixel pairs and accumulates K products into one partial sum. It emits that sum through a valid/ready output.
- Backpressure stalls the whole pipeline, so one PE can drive a column adder or an output buffer directly.

Parameters:
- DATA_WID, 16: signed width of weight and pixel.
- ACC_WID, 40: signed accumulator and psum_out width. Must be at least 2*DATA_WID.
- MULT_LAT, 2: multiplier register stages. Must be at least 1.
- K_WID, 8: width of k_len.

Ports:
- clock, in, 1: sole clock. Rising edge.
- rst, in, 1: synchronous reset, active-high.
- in_valid, in, 1: weight/pixel/k_len valid.
- in_ready, out, 1: PE can accept a pair this cycle.
- weight, in, DATA_WID: signed operand A.
- pixel, in, DATA_WID: signed operand B.
- k_len, in, K_WID: products per partial sum. Sampled on the first beat of each group only.
- out_valid, out, 1: psum_out holds a finished sum.
- out_ready, in, 1: consumer takes psum_out this cycle.
- psum_out, out, ACC_WID: signed accumulated partial sum.
- busy, out, 1: high while a group is partially accepted or any product is still in flight.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, psum_out=0, busy=0.
  - Accumulator, beat counter, all pipeline valid/last bits and the latched k_len all cleared.
  - A reset mid-group discards the group. No partial result is ever emitted.
  - in_ready is 0 during the reset cycle and 1 in the first cycle after reset.
- Global enable:
  - en = !out_valid || out_ready. in_ready = en.
  - When en=0, every pipeline register, the counter and the accumulator hold.
- Input accept:
  - A beat is accepted when in_valid && in_ready.
  - Beat counter cnt (K_WID bits) is 0 at the start of a group. On the first beat it latches kl = (k_len==0) ? 1 : k_len.
  - A beat is marked last when cnt == kl-1. cnt then returns to 0; otherwise cnt increments.
  - k_len presented on non-first beats is ignored.
- Multiply pipe:
  - Full-precision signed product of 2*DATA_WID bits, sign-extended to ACC_WID.
  - Valid and last bits travel alongside the product through MULT_LAT stages.
- Accumulate stage, on a product exiting the pipe with valid=1 and en=1:
  - sum = first ? prod : acc + prod, where first means the previous product was last, or this is the first product since reset.
  - If not last: acc <= sum.
  - If last: psum_out <= sum, out_valid <= 1, acc <= 0.
- Output handshake:
  - out_valid stays high with psum_out stable until out_ready=1.
  - A new result may load in the same cycle the old one is taken (out_valid && out_ready). This gives back-to-back groups with no bubble.
- Latency:
  - A last beat accepted at edge t gives out_valid=1 after edge t+MULT_LAT+1, with no stalls.
  - Throughput is 1 pair per cycle.
- Arithmetic:
  - Default is two's-complement wrap at ACC_WID.
  - With DATA_WID=16 and ACC_WID=40, groups of up to 256 products cannot overflow.
- Simultaneous events:
  - rst has priority over everything.
  - When in_valid=1 and out_ready=0 while out_valid=1, the input is not accepted and its data must be held by the producer.

Optional Feature:
- Macro: CMP_MAC_SAT_EN.
- Defined: each accumulate saturates to [-2^(ACC_WID-1), 2^(ACC_WID-1)-1]. Saturation is sticky for the rest of the group, so the emitted psum is the clamped value.
- Undefined: wrap arithmetic, no saturation logic.

Decomposition:
- Shared package cmp_pkg:
  - Default DATA_WID, ACC_WID, MULT_LAT and K_WID constants.
  - Typedefs for the data, accumulator and k_len types.
  - Saturating-add function used under CMP_MAC_SAT_EN.
- One sub-module, cmp_mult_pipe:
  - Parametrised signed multiplier, MULT_LAT stages, with enable input.
  - Carries the valid and last sideband bits through its stages.
  - Replaces the vendor multiplier IP.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> out_valid=0, psum_out=0, busy=0. in_ready=1 in the first cycle after rst drops.
2. K=4 group: pairs (3,5), (-2,7), (100,-100), (1,1) back-to-back, out_ready=1 -> single out_valid pulse with psum_out=-9998, 4+MULT_LAT cycles after the first beat.
3. Back-to-back groups: k_len=1, 8 consecutive pairs (i,i) for i=1..8 -> 8 consecutive out_valid cycles with psum_out=1,4,9,...,64 and no bubbles.
4. Backpressure: out_ready=0 while results are pending -> in_ready drops, psum_out is held, no beat is lost. After releasing out_ready, all results arrive in order with the correct values.
5. Extremes: k_len=0 with pair (-32768,-32768) -> treated as K=1, psum_out=1073741824. Four such pairs with K=4 -> 4294967296.
6. Reset mid-group: K=8, assert rst after 5 beats, then run a K=2 group (2,3),(4,5) -> only one result, psum_out=26. Under CMP_MAC_SAT_EN with ACC_WID=32, 4×(-32768)² clamps to 2147483647.
